// File: rtl/noc_params.sv
// Shared NoC parameters and types for the router's output-side arbiters.
package noc_params;

  localparam int unsigned PORT_NUM  = 5;
  localparam int unsigned VC_NUM    = 4;
  localparam int unsigned PORT_SIZE = $clog2(PORT_NUM);
  localparam int unsigned VC_SIZE   = $clog2(VC_NUM);

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set bit of mask_i scanning from ptr_i with wrap.
// Purely combinational; also reused by the switch allocator.
module rr_priority_picker #(
  parameter int unsigned Num  = 5,
  parameter int unsigned IdxW = $clog2(Num)
) (
  input  logic [Num-1:0]  mask_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [Num-1:0]  grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Scan ptr, ptr+1, ... keeping only the first hit so grant stays one-hot.
  always_comb begin
    logic [IdxW:0] k;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = '0;
    for (int unsigned off = 0; off < Num; off++) begin
      k = {1'b0, ptr_i} + (IdxW + 1)'(off);
      if (k >= (IdxW + 1)'(Num)) k = k - (IdxW + 1)'(Num);
      if (!valid_o && mask_i[k[IdxW-1:0]]) begin
        valid_o               = 1'b1;
        idx_o                 = k[IdxW-1:0];
        grant_o[k[IdxW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output wormhole arbiter: round-robin among input ports, holds the output
// from HEAD to TAIL and honours downstream per-VC on/off.
// Optional stall watchdog enabled by defining OUTPUT_ARB_WATCHDOG_EN.
module output_port_arbiter
  import noc_params::*;
#(
  parameter int unsigned PORT_NUM    = noc_params::PORT_NUM,
  parameter int unsigned VC_NUM      = noc_params::VC_NUM,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORT_NUM-1:0]               req_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]  req_vc_i,
  input  logic [PORT_NUM-1:0]               req_tail_i,
  input  logic [VC_NUM-1:0]                 on_off_i,
  output logic [PORT_NUM-1:0]               grant_o,
  output logic [PORT_SIZE-1:0]              xbar_sel_o,
  output logic                              valid_flit_o,
  output logic                              locked_o,
  output logic                              err_o
);

  localparam logic [PORT_SIZE-1:0] LastPort = PORT_SIZE'(PORT_NUM - 1);

  arb_state_t           state_q, state_d;
  logic [PORT_SIZE-1:0] rr_q, rr_d;
  logic [PORT_SIZE-1:0] owner_q, owner_d;
  logic [VC_SIZE-1:0]   lock_vc_q, lock_vc_d;
  logic [PORT_SIZE-1:0] sel_q;
  logic                 valid_q;

  logic [PORT_NUM-1:0]  eligible;
  logic [PORT_NUM-1:0]  pick_grant;
  logic [PORT_SIZE-1:0] pick_idx;
  logic                 pick_valid;
  logic [PORT_NUM-1:0]  grant;
  logic [PORT_SIZE-1:0] gnt_idx;
  logic                 gnt_valid;

  // An input is eligible when it requests and its downstream VC is on.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      eligible[i] = req_i[i] & on_off_i[req_vc_i[i]];
    end
  end

  rr_priority_picker #(
    .Num  (PORT_NUM),
    .IdxW (PORT_SIZE)
  ) u_picker (
    .mask_i  (eligible),
    .ptr_i   (rr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next-state and grant: free arbitration in IDLE, owner-only service in LOCKED.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    lock_vc_d = lock_vc_q;
    grant     = '0;
    gnt_idx   = owner_q;
    gnt_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant     = pick_grant;
          gnt_idx   = pick_idx;
          gnt_valid = 1'b1;
          if (req_tail_i[pick_idx]) begin
            rr_d = (pick_idx == LastPort) ? '0 : pick_idx + 1'b1;
          end else begin
            state_d   = LOCKED;
            owner_d   = pick_idx;
            lock_vc_d = req_vc_i[pick_idx];
          end
        end
      end
      LOCKED: begin
        // The owner's current req_vc_i is ignored; the VC latched at HEAD governs.
        if (req_i[owner_q] && on_off_i[lock_vc_q]) begin
          grant[owner_q] = 1'b1;
          gnt_valid      = 1'b1;
          if (req_tail_i[owner_q]) begin
            state_d = IDLE;
            rr_d    = (owner_q == LastPort) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state and crossbar pipeline registers; select holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      lock_vc_q <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      lock_vc_q <= lock_vc_d;
      valid_q   <= gnt_valid;
      if (gnt_valid) sel_q <= gnt_idx;
    end
  end

  assign grant_o      = rst ? '0 : grant;
  assign xbar_sel_o   = sel_q;
  assign valid_flit_o = valid_q;
  assign locked_o     = (state_q == LOCKED);

`ifdef OUTPUT_ARB_WATCHDOG_EN
  localparam int unsigned          StallW   = $clog2(STALL_LIMIT + 1);
  localparam logic [StallW-1:0]    StallMax = StallW'(STALL_LIMIT);

  logic [StallW-1:0] stall_q, stall_d;
  logic              err_q, err_d;

  // Count grantless LOCKED cycles, saturating; pulse err once on reaching the limit.
  always_comb begin
    stall_d = '0;
    if (state_q == LOCKED && !gnt_valid) begin
      stall_d = (stall_q == StallMax) ? stall_q : stall_q + 1'b1;
    end
    err_d = (stall_d == StallMax) && (stall_q != StallMax);
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_stall_limit;
  assign unused_stall_limit = ^STALL_LIMIT;
  assign err_o              = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: combinational grants are checked
// directly, registered crossbar outputs through a scoreboard queue.
module tb_output_port_arbiter;
  import noc_params::*;

`ifdef OUTPUT_ARB_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  typedef struct packed {
    logic                 v;
    logic [PORT_SIZE-1:0] sel;
  } exp_t;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [PORT_NUM-1:0]             req_i;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] req_vc_i;
  logic [PORT_NUM-1:0]             req_tail_i;
  logic [VC_NUM-1:0]               on_off_i;
  logic [PORT_NUM-1:0]             grant_o;
  logic [PORT_SIZE-1:0]            xbar_sel_o;
  logic                            valid_flit_o;
  logic                            locked_o;
  logic                            err_o;

  exp_t                 sb[$];
  logic [PORT_SIZE-1:0] exp_sel;
  int                   errors = 0;
  int                   checks = 0;

  output_port_arbiter #(
    .PORT_NUM    (PORT_NUM),
    .VC_NUM      (VC_NUM),
    .STALL_LIMIT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .req_vc_i     (req_vc_i),
    .req_tail_i   (req_tail_i),
    .on_off_i     (on_off_i),
    .grant_o      (grant_o),
    .xbar_sel_o   (xbar_sel_o),
    .valid_flit_o (valid_flit_o),
    .locked_o     (locked_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // One cycle: drive at negedge, check grant, push expectation, check registered outputs.
  task automatic step(input logic [4:0] req, input logic [4:0][1:0] vc, input logic [4:0] tail,
                      input logic [3:0] onoff, input logic [4:0] eg, input logic el,
                      input string name, input logic ee = 1'b0);
    exp_t e;
    @(negedge clk);
    req_i      = req;
    req_vc_i   = vc;
    req_tail_i = tail;
    on_off_i   = onoff;
    #1;
    checks++;
    if (grant_o !== eg) begin
      errors++;
      $display("FAIL %s grant: got %b want %b", name, grant_o, eg);
    end
    for (int i = 0; i < 5; i++) if (eg[i]) exp_sel = PORT_SIZE'(i);
    e.v   = (eg != 5'b0);
    e.sel = exp_sel;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty want entry", name);
    end else begin
      e = sb.pop_front();
      if (valid_flit_o !== e.v || xbar_sel_o !== e.sel) begin
        errors++;
        $display("FAIL %s xbar: got v=%b sel=%0d want v=%b sel=%0d", name, valid_flit_o,
                 xbar_sel_o, e.v, e.sel);
      end
    end
    checks++;
    if (locked_o !== el) begin
      errors++;
      $display("FAIL %s locked: got %b want %b", name, locked_o, el);
    end
    checks++;
    if (err_o !== ee) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, err_o, ee);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_i      = '1;
    req_vc_i   = '0;
    req_tail_i = '0;
    on_off_i   = '1;
    exp_sel    = '0;
    #12;
    checks++;
    if (grant_o !== 5'b0 || valid_flit_o !== 1'b0 || xbar_sel_o !== '0 || locked_o !== 1'b0 ||
        err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: got g=%b v=%b sel=%0d l=%b e=%b want all zero", grant_o,
               valid_flit_o, xbar_sel_o, locked_o, err_o);
    end
    @(negedge clk);
    rst   = 1'b0;
    req_i = '0;
  endtask

  task automatic test_headtail();
    step(5'b01010, '0, 5'b01010, 4'hf, 5'b00010, 1'b0, "headtail_first");
    step(5'b01000, '0, 5'b01000, 4'hf, 5'b01000, 1'b0, "headtail_second");
  endtask

  task automatic test_wrap();
    step(5'b10001, '0, 5'b10001, 4'hf, 5'b10000, 1'b0, "wrap_p4");
    step(5'b00001, '0, 5'b00001, 4'hf, 5'b00001, 1'b0, "wrap_p0");
    step(5'b00000, '0, 5'b00000, 4'hf, 5'b00000, 1'b0, "idle_bubble");
  endtask

  task automatic test_wormhole();
    logic [4:0][1:0] vc;
    vc = 10'b01_00_00_00_00;
    step(5'b10100, vc, 5'b10000, 4'hf, 5'b00100, 1'b1, "worm_head");
    step(5'b10100, vc, 5'b10000, 4'hf, 5'b00100, 1'b1, "worm_body1");
    step(5'b10100, vc, 5'b10000, 4'hf, 5'b00100, 1'b1, "worm_body2");
    step(5'b10100, vc, 5'b10100, 4'hf, 5'b00100, 1'b0, "worm_tail");
    step(5'b10000, vc, 5'b10000, 4'hf, 5'b10000, 1'b0, "worm_next");
  endtask

  task automatic test_vc_stall();
    logic [4:0][1:0] vc;
    vc = 10'b00_00_00_00_01;
    step(5'b01001, vc, 5'b01000, 4'hf, 5'b00001, 1'b1, "stall_head");
    for (int i = 0; i < 3; i++) begin
      // Owner's live VC points at an open VC; the latched VC 1 is off, so no grant.
      step(5'b01001, '0, 5'b01000, 4'b1101, 5'b00000, 1'b1, "stall_off");
    end
    step(5'b01001, vc, 5'b01000, 4'hf, 5'b00001, 1'b1, "stall_resume");
    step(5'b01001, vc, 5'b01001, 4'hf, 5'b00001, 1'b0, "stall_tail");
    step(5'b01000, vc, 5'b01000, 4'hf, 5'b01000, 1'b0, "stall_other");
  endtask

  task automatic test_async_reset();
    step(5'b10000, '0, 5'b00000, 4'hf, 5'b10000, 1'b1, "arst_head");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (grant_o !== 5'b0 || valid_flit_o !== 1'b0 || xbar_sel_o !== '0 || locked_o !== 1'b0 ||
        err_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got g=%b v=%b sel=%0d l=%b e=%b want all zero", grant_o,
               valid_flit_o, xbar_sel_o, locked_o, err_o);
    end
    sb.delete();
    exp_sel = '0;
    @(negedge clk);
    rst   = 1'b0;
    req_i = '0;
  endtask

  task automatic test_watchdog();
    step(5'b00001, '0, 5'b00000, 4'hf, 5'b00001, 1'b1, "wd_head");
    for (int i = 1; i <= 12; i++) begin
      step(5'b00000, '0, 5'b00000, 4'hf, 5'b00000, 1'b1, "wd_stall", WdEn && (i == 8));
    end
  endtask

  initial begin
    test_reset();
    test_headtail();
    test_wrap();
    test_wormhole();
    test_vc_stall();
    test_async_reset();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
